// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit half of the bfCPU UART path. Bytes written by the IO path (WE
// strobe + DIN) are buffered in a DEPTH-entry FIFO and sent LSB-first on TXD
// as 8N1 frames. When UART_TX_PARITY_EN is defined, an even-parity bit is
// inserted after D7, giving 8E1 frames. The FIFO is popped only at frame start.
// Bit timing comes from the SIO_CE pulse of the baud-rate generator.
//
// Optional feature macro: UART_TX_PARITY_EN (even parity, 11-tick frames).
//
// Parameters
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   CLK     in   system clock, rising edge
//   RES     in   synchronous active-high reset
//   SIO_CE  in   one-CLK bit-period tick (each high cycle is one tick)
//   WE      in   push strobe
//   DIN     in   [7:0] byte to push
//   CTS_I   in   1 = do not start a new frame
//   FULL    out  FIFO holds DEPTH bytes
//   EMPTY   out  FIFO holds no bytes
//   LEVEL   out  [$clog2(DEPTH):0] FIFO occupancy
//   BUSY    out  serialiser not idle
//   TXD     out  serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic                     SIO_CE,
    input  logic                     WE,
    input  logic [7:0]               DIN,
    input  logic                     CTS_I,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     BUSY,
    output logic                     TXD
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_e;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;

    logic full, empty, push, pop, avail;
    logic [7:0] head;

    state_e state_q, state_d;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rptr_q];

    // A dropped write (FULL) is dropped even if a pop frees a slot the
    // same cycle: FULL is the registered view the writer already acted on.
    assign push  = WE && !full;

    // CTS_I only matters at frame start, which is exactly where we pop.
    assign avail = !empty && !CTS_I;
    assign pop   = SIO_CE && avail && ((state_q == S_IDLE) || (state_q == S_STOP));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage has no reset; discarding contents on RES is done by the
    // pointers and level returning to zero.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [7:0] shr_q, shr_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RES) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; nothing moves without a tick
    always_comb begin
        state_d = state_q;
        if (SIO_CE) begin
            case (state_q)
                S_IDLE:   if (pop) state_d = S_START;
                S_START:  state_d = S_DATA;
                S_DATA: begin
                    if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: state_d = S_STOP;
`endif
                S_STOP:   state_d = pop ? S_START : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath logic. TXD is loaded with the value of the bit
    // period that begins at this tick, so the line is glitch-free.
    always_comb begin
        txd_d    = txd_q;
        shr_d    = shr_q;
        bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (SIO_CE) begin
            case (state_q)
                S_IDLE, S_STOP: begin
                    if (pop) begin
                        shr_d    = head;
                        txd_d    = 1'b0;
                        bitcnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^head;
`endif
                    end else begin
                        txd_d = 1'b1;
                    end
                end
                S_START: begin
                    txd_d = shr_q[0];
                    shr_d = {1'b0, shr_q[7:1]};
                end
                S_DATA: begin
                    if (bitcnt_q != 3'd7) begin
                        txd_d    = shr_q[0];
                        shr_d    = {1'b0, shr_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d = par_q;
`else
                        txd_d = 1'b1;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: txd_d = 1'b1;
`endif
                default: txd_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            txd_q    <= 1'b1;
            shr_q    <= '0;
            bitcnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            txd_q    <= txd_d;
            shr_q    <= shr_d;
            bitcnt_q <= bitcnt_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign FULL  = full;
    assign EMPTY = empty;
    assign LEVEL = level_q;
    assign BUSY  = (state_q != S_IDLE);
    assign TXD   = txd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed scenarios plus a random phase, all
// checked cycle by cycle against a frame-level model (byte queue + queue of
// pending line bits).
module tb_uart_tx_serializer;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RES, SIO_CE, WE, CTS_I;
    logic [7:0] DIN;
    logic       FULL, EMPTY, BUSY, TXD;
    logic [2:0] LEVEL;

    uart_tx_serializer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RES(RES), .SIO_CE(SIO_CE), .WE(WE), .DIN(DIN),
        .CTS_I(CTS_I), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
        .BUSY(BUSY), .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];   // bytes waiting in the FIFO
    logic       bq[$];   // line bits still to be shown for the current frame
    logic       m_txd  = 1'b1;
    logic       m_busy = 1'b0;

    // Per-tick log of the line, used by the directed frame checks
    logic       tlog[$];
    logic       blog[$];

    task automatic model_edge();
        int n;
        logic [7:0] b;
        if (RES) begin
            mq.delete(); bq.delete();
            m_txd = 1'b1; m_busy = 1'b0;
            return;
        end
        n = mq.size();
        if (SIO_CE) begin
            if (bq.size() > 0) begin
                m_txd = bq.pop_front();
            end else if (n > 0 && !CTS_I) begin
                b = mq.pop_front();
                for (int i = 0; i < 8; i++) bq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                bq.push_back(^b);
`endif
                bq.push_back(1'b1);
                m_txd  = 1'b0;
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
        end
        if (WE && n < DEPTH) mq.push_back(DIN);
    endtask

    task automatic step(input logic ce, input logic we, input logic [7:0] din,
                        input logic cts, input logic res);
        SIO_CE = ce; WE = we; DIN = din; CTS_I = cts; RES = res;
        @(posedge CLK);
        model_edge();
        #1;
        chk("txd",   TXD,   m_txd);
        chk("busy",  BUSY,  m_busy);
        chk("level", LEVEL, mq.size());
        chk("full",  FULL,  mq.size() == DEPTH);
        chk("empty", EMPTY, mq.size() == 0);
        if (ce) begin
            tlog.push_back(TXD);
            blog.push_back(BUSY);
        end
    endtask

    // n ticks, one every per cycles, no writes
    task automatic run_ticks(input int n, input int per, input logic cts);
        for (int t = 0; t < n; t++)
            for (int c = 0; c < per; c++)
                step(c == 0, 1'b0, 8'h00, cts, 1'b0);
    endtask

    function automatic logic [11:0] pack12(input logic q[$]);
        logic [11:0] v = '0;
        for (int i = 0; i < 12 && i < q.size(); i++) v[i] = q[i];
        return v;
    endfunction

    // Push one byte into an idle serializer and log 12 ticks of the line
    task automatic send_and_log(input logic [7:0] b, input int per,
                                output logic [11:0] tx, output logic [11:0] bz);
        tlog.delete(); blog.delete();
        step(1'b0, 1'b1, b, 1'b0, 1'b0);
        run_ticks(12, per, 1'b0);
        tx = pack12(tlog);
        bz = pack12(blog);
    endtask

    logic [11:0] tx, bz;
    logic cts_r;

    initial begin
        RES = 1'b1; SIO_CE = 1'b0; WE = 1'b0; DIN = '0; CTS_I = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_txd", TXD, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);

        // A5 frame, tick every 4 clocks
        send_and_log(8'hA5, 4, tx, bz);
`ifdef UART_TX_PARITY_EN
        chk("a5_line", tx, 12'hD4A);
        chk("a5_busy", bz, 12'h7FF);
`else
        chk("a5_line", tx, 12'hF4A);
        chk("a5_busy", bz, 12'h3FF);
`endif
        chk("a5_idle_busy", BUSY, 0);
        chk("a5_idle_empty", EMPTY, 1);

        // Fill past DEPTH with no ticks: 8'h04 dropped
        for (int i = 0; i < 5; i++) step(0, 1, 8'(i), 0, 0);
        chk("fill_level", LEVEL, 4);
        chk("fill_full", FULL, 1);
        tlog.delete();
        run_ticks(48, 2, 0);
        chk("fill_drain_empty", EMPTY, 1);
        chk("fill_drain_busy", BUSY, 0);

        // CTS hold-off, then release, then raise mid-frame
        step(0, 1, 8'h55, 1, 0);
        run_ticks(20, 2, 1);
        chk("cts_level", LEVEL, 1);
        chk("cts_txd", TXD, 1);
        run_ticks(4, 2, 0);
        run_ticks(16, 2, 1);
        chk("cts_done_level", LEVEL, 0);
        run_ticks(2, 2, 0);

        // Reset in the middle of an FF frame with two bytes queued
        step(0, 1, 8'hFF, 0, 0);
        step(0, 1, 8'hAA, 0, 0);
        step(0, 1, 8'h11, 0, 0);
        run_ticks(6, 3, 0);
        step(0, 0, 0, 0, 1);
        chk("mid_rst_txd", TXD, 1);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_level", LEVEL, 0);
        run_ticks(20, 2, 0);
        chk("mid_rst_quiet", TXD, 1);

        // Simultaneous push and pop at LEVEL=2
        step(0, 1, 8'h3C, 0, 0);
        step(0, 1, 8'hC3, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        chk("pushpop_level", LEVEL, 2);
        // Ten pushes across pointer wrap, interleaved with frames
        for (int i = 0; i < 10; i++) begin
            while (FULL) run_ticks(1, 2, 0);
            step(0, 1, 8'(8'h80 + i), 0, 0);
            run_ticks(3, 2, 0);
        end
        run_ticks(150, 2, 0);
        chk("wrap_empty", EMPTY, 1);

        // Parity / frame-length checks
        send_and_log(8'h07, 2, tx, bz);
        chk("b07_line", tx, 12'hE0E);
`ifdef UART_TX_PARITY_EN
        chk("b07_busy", bz, 12'h7FF);
`else
        chk("b07_busy", bz, 12'h3FF);
`endif
        send_and_log(8'h03, 2, tx, bz);
`ifdef UART_TX_PARITY_EN
        chk("b03_line", tx, 12'hC06);
        chk("b03_busy", bz, 12'h7FF);
`else
        chk("b03_line", tx, 12'hE06);
        chk("b03_busy", bz, 12'h3FF);
`endif

        // Random phase
        cts_r = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 49) == 0) cts_r = ~cts_r;
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 8'($urandom),
                 cts_r,
                 $urandom_range(0, 1999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
